instr_fetch_unit: RTL

//  IF stage of the pipeline: generates PC, issues in-order requests to the instruction

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/fetch_fifo_chk.sv | 20 ++
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package fetch_pkg;

    localparam int FETCH_XLEN     = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    // Counters must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; the head entry is presented combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W = cnt_width(FIFO_DEPTH_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             empty_s;
    logic             full_s;

    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    assign do_pop_s  = pop && !flush && !empty_s;
    assign do_push_s = push && !flush && (!full_s || do_pop_s);

    // Entry storage; occupancy is tracked by the counters, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = empty_s;
    assign full  = full_s;
    assign count = count_r;

    fetch_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checks for the prefetch FIFO: the upstream credit scheme must prevent overflow.
module fetch_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic flush,
    input logic full,
    input logic empty
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && full))
        else $error("fetch_fifo: push into full FIFO");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && empty))
        else $error("fetch_fifo: pop from empty FIFO");

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC generation, credit-limited in-order imem requests, prefetch FIFO, redirect flush.
// Optional FETCH_MISALIGN_EN: a misaligned redirect target halts fetch and reports FetchErrD.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = FETCH_XLEN,
    parameter int              FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            StallD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            FetchErrD
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  pcf_r;
    logic [XLEN-1:0]  resp_pc_r;
    logic [XLEN-1:0]  target_s;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] outstanding_nxt_s;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0] fifo_count_s;
    logic [CNT_W:0]   inflight_s;
    logic             halted_s;
    logic             accept_s;
    logic             drop_zero_s;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;
    logic             err_valid_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;

`ifdef FETCH_MISALIGN_EN
    logic halted_r;

    // A misaligned redirect parks fetch until the next redirect arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else if (PCSrcE) begin
            halted_r <= (PCTargetE[1:0] != 2'b00);
        end else begin
            halted_r <= halted_r;
        end
    end

    assign halted_s = halted_r;
    assign target_s = PCTargetE;
`else
    assign halted_s = 1'b0;
    assign target_s = PCTargetE & ~XLEN'(3);
`endif

    // Total slots claimed: requests still in flight plus entries already buffered.
    assign inflight_s     = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
    assign imem_req_valid = rst_n && !PCSrcE && !halted_s && (inflight_s < CREDIT_MAX);
    assign imem_addr      = pcf_r;
    assign accept_s       = imem_req_valid && imem_req_ready;

    assign drop_zero_s  = (drop_cnt_r == {CNT_W{1'b0}});
    assign push_s       = imem_rsp_valid && !PCSrcE && drop_zero_s;
    assign pop_s        = !empty_s && !StallD && !PCSrcE;
    assign push_entry_s = '{pc: resp_pc_r, instr: imem_rsp_data};
    assign err_valid_s  = halted_s && (outstanding_r == {CNT_W{1'b0}}) && drop_zero_s;

    // Outstanding request count after this cycle's accept and response.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({accept_s, imem_rsp_valid})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_W'(1);
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_W'(1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Fetch PC and response PC; a redirect reloads both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_r     <= RESET_PC;
            resp_pc_r <= RESET_PC;
        end else if (PCSrcE) begin
            pcf_r     <= target_s;
            resp_pc_r <= target_s;
        end else begin
            if (accept_s) begin
                pcf_r <= pcf_r + XLEN'(4);
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + XLEN'(4);
            end
        end
    end

    // In-flight accounting; on redirect every remaining in-flight response is wrong-path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= {CNT_W{1'b0}};
            drop_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (PCSrcE) begin
                drop_cnt_r <= outstanding_nxt_s;
            end else if (imem_rsp_valid && !drop_zero_s) begin
                drop_cnt_r <= drop_cnt_r - CNT_W'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (PCSrcE),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (empty_s),
        .full      (full_s),
        .count     (fifo_count_s)
    );

    // Decode view: error marker first, then FIFO head, otherwise a NOP bubble.
    always_comb begin
        ValidD    = 1'b0;
        InstrD    = NOP_INSTR;
        PCD       = {XLEN{1'b0}};
        PCPlus4D  = XLEN'(4);
        FetchErrD = 1'b0;
        if (err_valid_s) begin
            ValidD    = 1'b1;
            PCD       = resp_pc_r;
            PCPlus4D  = resp_pc_r + XLEN'(4);
            FetchErrD = 1'b1;
        end else if (!empty_s) begin
            ValidD   = 1'b1;
            InstrD   = head_s.instr;
            PCD      = head_s.pc;
            PCPlus4D = head_s.pc + XLEN'(4);
        end else begin
            ValidD = 1'b0;
        end
    end

endmodule
